// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - Instruction fetch stage: PC, 16x32 instruction memory, LOAD/RUN/HALT control.
module if_fetch_unit #(
   parameter logic [3:0]  START_PC  = 4'd0,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        imem_we,
   input  logic [3:0]  imem_waddr,
   input  logic [31:0] imem_wdata,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [3:0]  redirect_pc,
   output logic [31:0] Instruction_Code,
   output logic [3:0]  PC_IF,
   output logic        flush,
   output logic        halted,
   output logic [7:0]  fetch_count
);

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [3:0]  pc, pc_nxt;
   logic [7:0]  cnt, cnt_nxt;
   logic [31:0] imem [16];
   logic [31:0] fetch_word;

   // Memory has no reset so a program survives reset and can be rerun.
   always_ff @(posedge clk) begin
      if (state == ST_LOAD && imem_we)
         imem[imem_waddr] <= imem_wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_LOAD;
         pc    <= START_PC;
         cnt   <= 8'd0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         cnt   <= cnt_nxt;
      end
   end

   assign fetch_word = imem[pc];

   always_comb begin
      state_nxt        = state;
      pc_nxt           = pc;
      cnt_nxt          = cnt;
      Instruction_Code = 32'd0;
      flush            = 1'b0;
      halted           = 1'b0;
      case (state)
         ST_LOAD: begin
            if (start) begin
               state_nxt = ST_RUN;
               pc_nxt    = START_PC;
            end
         end
         ST_RUN: begin
            Instruction_Code = fetch_word;
            if (redirect_valid) begin
               pc_nxt = redirect_pc;
               flush  = 1'b1;
            end else if (!stall) begin
               // Word is accepted by IF/ID this cycle, including a halt word.
               cnt_nxt = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
               if (fetch_word == HALT_WORD)
                  state_nxt = ST_HALT;
               else
                  pc_nxt = pc + 4'd1;
            end
         end
         ST_HALT: begin
            halted = 1'b1;
         end
         default: begin
            state_nxt = ST_LOAD;
         end
      endcase
   end

   assign PC_IF       = pc;
   assign fetch_count = cnt;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - Directed scoreboard bench for if_fetch_unit.
module tb_if_fetch_unit;

   localparam logic [31:0] HALT = 32'hFFFF_FFFF;
   localparam logic [31:0] A0 = 32'hA000_0000;
   localparam logic [31:0] A1 = 32'hA111_1111;
   localparam logic [31:0] A2 = 32'hA222_2222;

   logic        clk = 1'b0;
   logic        reset, start, imem_we, stall, redirect_valid;
   logic [3:0]  imem_waddr, redirect_pc;
   logic [31:0] imem_wdata;
   logic [31:0] Instruction_Code;
   logic [3:0]  PC_IF;
   logic        flush, halted;
   logic [7:0]  fetch_count;

   if_fetch_unit dut (
      .clk(clk), .reset(reset), .start(start), .imem_we(imem_we),
      .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .Instruction_Code(Instruction_Code), .PC_IF(PC_IF), .flush(flush),
      .halted(halted), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [3:0]  pc;
      logic [31:0] ins;
      logic        fl;
      logic        hl;
      logic [7:0]  cnt;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   function automatic logic [31:0] w(int i);
      return 32'hC000_0000 | 32'(i);
   endfunction

   task automatic cmp(string tag, string f, logic [31:0] got, logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s.%s got=%h want=%h", tag, f, got, want);
      end
   endtask

   task automatic expect_now(string tag, logic [3:0] pc, logic [31:0] ins,
                             logic fl, logic hl, logic [7:0] cnt);
      exp_t e;
      e.tag = tag; e.pc = pc; e.ins = ins; e.fl = fl; e.hl = hl; e.cnt = cnt;
      sb.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard got=empty want=entry");
      end else begin
         e = sb.pop_front();
         cmp(e.tag, "pc",     {28'd0, PC_IF},       {28'd0, e.pc});
         cmp(e.tag, "instr",  Instruction_Code,     e.ins);
         cmp(e.tag, "flush",  {31'd0, flush},       {31'd0, e.fl});
         cmp(e.tag, "halted", {31'd0, halted},      {31'd0, e.hl});
         cmp(e.tag, "count",  {24'd0, fetch_count}, {24'd0, e.cnt});
      end
   endtask

   task automatic cyc(string tag, logic st, logic rv, logic [3:0] rp,
                      logic [3:0] epc, logic [31:0] ein, logic efl, logic ehl, logic [7:0] ecnt);
      stall = st; redirect_valid = rv; redirect_pc = rp;
      expect_now(tag, epc, ein, efl, ehl, ecnt);
      @(negedge clk);
      pop_check();
      @(posedge clk);
      #1;
      stall = 1'b0; redirect_valid = 1'b0; start = 1'b0; imem_we = 1'b0;
   endtask

   task automatic wr(logic [3:0] a, logic [31:0] d);
      imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
      @(posedge clk);
      #1;
      imem_we = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; imem_we = 1'b0; stall = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 4'd5; imem_waddr = 4'd0; imem_wdata = 32'd0;
      #2;
      expect_now("reset", 4'd0, 32'd0, 1'b0, 1'b0, 8'd0);
      pop_check();
      @(posedge clk);
      #1;
      reset = 1'b1; redirect_valid = 1'b0;

      // Program 1: short run ending on a halt word written in the start cycle.
      cyc("load_noflush", 1'b0, 1'b1, 4'd7, 4'd0, 32'd0, 1'b0, 1'b0, 8'd0);
      wr(4'd0, A0); wr(4'd1, A1); wr(4'd2, A2);
      start = 1'b1; imem_we = 1'b1; imem_waddr = 4'd3; imem_wdata = HALT;
      cyc("start_wr", 1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 1'b0, 8'd0);
      cyc("r0", 1'b0, 1'b0, 4'd0, 4'd0, A0,   1'b0, 1'b0, 8'd0);
      cyc("r1", 1'b0, 1'b0, 4'd0, 4'd1, A1,   1'b0, 1'b0, 8'd1);
      cyc("r2", 1'b0, 1'b0, 4'd0, 4'd2, A2,   1'b0, 1'b0, 8'd2);
      cyc("r3", 1'b0, 1'b0, 4'd0, 4'd3, HALT, 1'b0, 1'b0, 8'd3);
      start = 1'b1; imem_we = 1'b1; imem_waddr = 4'd0; imem_wdata = 32'd0;
      cyc("h0", 1'b0, 1'b1, 4'd9, 4'd3, 32'd0, 1'b0, 1'b1, 8'd4);
      cyc("h1", 1'b1, 1'b0, 4'd0, 4'd3, 32'd0, 1'b0, 1'b1, 8'd4);

      // Program 2: no halt word; stalls, redirects, ignored RUN write, wrap.
      do_reset();
      for (int i = 0; i < 16; i++) wr(4'(i), w(i));
      start = 1'b1;
      cyc("start2", 1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 1'b0, 8'd0);
      cyc("p0",      1'b0, 1'b0, 4'd0, 4'd0, w(0), 1'b0, 1'b0, 8'd0);
      cyc("p1",      1'b0, 1'b0, 4'd0, 4'd1, w(1), 1'b0, 1'b0, 8'd1);
      cyc("stall_a", 1'b1, 1'b0, 4'd0, 4'd2, w(2), 1'b0, 1'b0, 8'd2);
      cyc("stall_b", 1'b1, 1'b0, 4'd0, 4'd2, w(2), 1'b0, 1'b0, 8'd2);
      cyc("stall_c", 1'b1, 1'b0, 4'd0, 4'd2, w(2), 1'b0, 1'b0, 8'd2);
      cyc("unstall", 1'b0, 1'b0, 4'd0, 4'd2, w(2), 1'b0, 1'b0, 8'd2);
      imem_we = 1'b1; imem_waddr = 4'd5; imem_wdata = 32'h1234_5678;
      cyc("run_we",  1'b0, 1'b0, 4'd0, 4'd3, w(3), 1'b0, 1'b0, 8'd3);
      cyc("redir_stall", 1'b1, 1'b1, 4'd9, 4'd4, w(4), 1'b1, 1'b0, 8'd4);
      cyc("redir_tgt",   1'b0, 1'b0, 4'd0, 4'd9, w(9), 1'b0, 1'b0, 8'd4);
      for (int k = 10; k < 16; k++)
         cyc($sformatf("seq%0d", k), 1'b0, 1'b0, 4'd0, 4'(k), w(k), 1'b0, 1'b0, 8'(k - 5));
      cyc("wrap0",  1'b0, 1'b0, 4'd0, 4'd0, w(0), 1'b0, 1'b0, 8'd11);
      cyc("redir5", 1'b0, 1'b1, 4'd5, 4'd1, w(1), 1'b1, 1'b0, 8'd12);
      cyc("imem5",  1'b0, 1'b0, 4'd0, 4'd5, w(5), 1'b0, 1'b0, 8'd12);
      cyc("p6",     1'b0, 1'b0, 4'd0, 4'd6, w(6), 1'b0, 1'b0, 8'd13);

      // Asynchronous reset in the middle of the PC=7 cycle.
      expect_now("p7", 4'd7, w(7), 1'b0, 1'b0, 8'd14);
      @(negedge clk);
      pop_check();
      #1;
      reset = 1'b0; redirect_valid = 1'b1; redirect_pc = 4'd3;
      #1;
      expect_now("async_rst", 4'd0, 32'd0, 1'b0, 1'b0, 8'd0);
      pop_check();
      @(posedge clk);
      #1;
      reset = 1'b1; redirect_valid = 1'b0;

      // Rerun preserved program: wrap and fetch_count saturation.
      start = 1'b1;
      cyc("restart", 1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 1'b0, 8'd0);
      for (int k = 0; k < 260; k++)
         cyc($sformatf("run%0d", k), 1'b0, 1'b0, 4'd0, 4'(k), w(k % 16), 1'b0, 1'b0,
             8'((k > 255) ? 255 : k));

      // Halt word under redirect and stall.
      do_reset();
      wr(4'd0, HALT); wr(4'd1, HALT);
      start = 1'b1;
      cyc("start3",     1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 1'b0, 8'd0);
      cyc("halt_redir", 1'b0, 1'b1, 4'd1, 4'd0, HALT,  1'b1, 1'b0, 8'd0);
      cyc("halt_stall", 1'b1, 1'b0, 4'd0, 4'd1, HALT,  1'b0, 1'b0, 8'd0);
      cyc("halt_go",    1'b0, 1'b0, 4'd0, 4'd1, HALT,  1'b0, 1'b0, 8'd0);
      cyc("halted2",    1'b0, 1'b0, 4'd0, 4'd1, 32'd0, 1'b0, 1'b1, 8'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
